lsu_ctrl: RTL
=============

# lsu_ctrl

Parametrised load/store unit that sits between the core's execute stage and a valid/ready data bus. It replaces the single-cycle combinational memory path with a handshaked, multi-cycle access sequencer. It generates byte strobes and shifted write data, and splits any access that crosses a bus word boundary into two beats. On reads it merges the beats and sign- or zero-extends the result.

## Interface
- DW, 64, core and bus data width; only 32 or 64 are legal
- AW, 64, address width
- NB (derived), DW/8, bytes per bus word; OB (derived) = log2(NB)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned  in  1  zero-extend the load result (lbu/lhu/lwu)
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DW  extended load data; 0 for stores
- resp_err  out  1  valid with resp_valid; illegal size
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts the request
- bus_we  out  1  bus write
- bus_addr  out  AW  NB-aligned address (low OB bits are 0)
- bus_wdata  out  DW  lane-positioned write data
- bus_wstrb  out  NB  byte enables; all 0 on reads
- bus_rvalid  in  1  response/ack for the outstanding beat (reads and writes)
- bus_rdata  in  DW  read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready = 1.
  - On a handshake, latch we, size, unsigned, addr and wdata. Compute off = addr[OB-1:0] and nbytes = 1 << size.
  - If size > OB, go to RESP with err = 1 and issue no bus traffic.
  - Otherwise go to REQ0.
- Split condition: split = (off + nbytes > NB).
- REQ0:
  - bus_valid = 1; bus_addr = {addr[AW-1:OB], 0}.
  - wstrb = (mask(nbytes) << off)[NB-1:0].
  - wdata = (wdata << 8*off)[DW-1:0].
  - On bus_ready, go to WAIT0.
- WAIT0:
  - On bus_rvalid, capture rdata0.
  - Then go to REQ1 if split, else RESP.
- REQ1:
  - bus_addr = previous aligned address + NB. Wrap modulo 2^AW; there is no fault.
  - wstrb = mask(nbytes) >> (NB-off).
  - wdata = wdata >> 8*(NB-off).
  - On bus_ready, go to WAIT1.
- WAIT1: on bus_rvalid, capture rdata1 and go to RESP.
- RESP:
  - resp_valid = 1 for one cycle, then go to IDLE.
  - Load data: take {rdata1, rdata0} >> 8*off, keep the low nbytes, then extend to DW. Zero-extend if unsigned, else sign-extend from the top byte.
  - When not split, rdata1 is treated as 0.
  - Stores return resp_rdata = 0.
- bus_rvalid is accepted only in WAIT0/WAIT1. It must not arrive in the cycle of its own request handshake. In any other state it is ignored.
- Only one bus beat is ever outstanding.

## Timing
- Reset values:
  - State = IDLE.
  - req_ready = 1; all other outputs = 0. This includes bus_valid, bus_wstrb, resp_valid, resp_err, resp_rdata and busy.
- req_ready is combinational from state only. It never depends on req_valid.
- While bus_valid = 1 and bus_ready = 0, bus_addr, bus_we, bus_wdata and bus_wstrb hold stable.
- Latency, with a zero-wait bus (bus_ready always 1, rvalid one cycle after the handshake):
  - Request accepted in cycle N.
  - Unsplit: bus_valid in N+1, rvalid in N+2, resp_valid in N+3.
  - Split: resp_valid in N+5.
  - Illegal size: resp_valid in N+1, with no bus_valid.
- A new request can be accepted in the cycle after resp_valid, because the FSM is back in IDLE with req_ready = 1.
- Reset asserted in any state:
  - Next cycle: IDLE, bus_valid = 0, no resp_valid.
  - A late bus_rvalid from the aborted beat is ignored.
- Offsets at the top of a bus word with no split are legal single beats: off = NB-1 with size 0, or off = NB-2 with size 1.

## Test plan
- Aligned store, DW = 64, zero-wait bus.
  - Stimulus: sd, addr 0x80000008, wdata 0x1122334455667788.
  - Response: one beat with bus_addr 0x80000008, wstrb 0xFF, wdata unchanged; resp_valid exactly 3 cycles after accept.
- Signed and unsigned byte load, addr 0x80000003, bus_rdata 0x0000000080000000.
  - lb returns resp_rdata 0xFFFFFFFFFFFFFF80.
  - lbu returns 0x0000000000000080.
- Misaligned word load, lw at 0x80000006.
  - Beat 0: bus_addr 0x80000000; rdata0 = 0xDDCC000000000000.
  - Beat 1: bus_addr 0x80000008; rdata1 = 0x000000000000FFEE.
  - resp_rdata = 0xFFFFFFFFFFEEDDCC; lwu returns 0x00000000FFEEDDCC.
- Misaligned halfword store, sh at 0x8000000F, wdata 0xBEEF.
  - Beat 0: bus_addr 0x80000008, wstrb 0x80, wdata 0xEF00000000000000.
  - Beat 1: bus_addr 0x80000010, wstrb 0x01, wdata 0x00000000000000BE.
- Backpressure: hold bus_ready = 0 for 3 cycles in REQ0.
  - Bus outputs stay constant and req_ready stays 0.
  - Total latency grows by exactly 3 cycles.
- Reset and error cases:
  - Assert rst in WAIT1, then pulse bus_rvalid. Required: IDLE and req_ready = 1 next cycle, and no resp_valid ever.
  - With DW = 32, issue size 3. Required: resp_err = 1 with resp_valid one cycle after accept, and bus_valid never asserted.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Signal bundle between the execute stage, lsu_ctrl and the data bus.
// slave is the load/store unit's view; master is the core plus bus side.
interface lsu_ctrl_if #(
  parameter int DW = 64,
  parameter int AW = 64
);
  // Both channels use valid/ready: a transfer happens on the rising edge where
  // valid and ready are both high, and the payload must stay put until then.
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic            bus_valid;
  logic            bus_ready;
  logic            bus_we;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_wstrb;
  logic            bus_rvalid;
  logic [DW-1:0]   bus_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           bus_ready, bus_rvalid, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one or two bus beats per access, byte strobes,
// lane shifting on stores, beat merge and sign/zero extension on loads.
module lsu_ctrl #(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  io,
  output logic       busy,
  output logic [2:0] dbg_state
);
  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;

  logic            accept, size_bad, split, fill;
  logic [OB-1:0]   off;
  logic [OB:0]     nbytes;
  logic [OB+1:0]   span;
  logic [NB-1:0]   mask;
  logic [2*NB-1:0] strb_sh;
  logic [2*DW-1:0] wd_sh;
  logic [DW-1:0]   rd_sh, load_data;
  logic [AW-1:0]   base_addr;

  assign accept   = io.req_valid && io.req_ready;
  assign size_bad = {1'b0, io.req_size} > 3'(OB);

  assign off       = addr_q[OB-1:0];
  assign nbytes    = {{OB{1'b0}}, 1'b1} << size_q;
  assign span      = {2'b00, off} + {1'b0, nbytes};
  assign split     = span > (OB+2)'(NB);
  assign base_addr = {addr_q[AW-1:OB], {OB{1'b0}}};

  // Shifting across a double-width window gives beat 0 in the low half and
  // the spill-over for beat 1 in the high half.
  assign strb_sh = {{NB{1'b0}}, mask} << off;
  assign wd_sh   = {{DW{1'b0}}, wdata_q} << {off, 3'b000};
  assign rd_sh   = DW'({rdata1_q, rdata0_q} >> {off, 3'b000});

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) mask[i] = (OB+1)'(i) < nbytes;
  end

  always_comb begin
    fill = 1'b0;
    case (size_q)
      2'd0:    fill = rd_sh[7];
      2'd1:    fill = rd_sh[15];
      2'd2:    fill = rd_sh[31];
      default: fill = rd_sh[DW-1];
    endcase
    fill      = fill && !uns_q;
    load_data = '0;
    for (int i = 0; i < NB; i++)
      load_data[8*i +: 8] = mask[i] ? rd_sh[8*i +: 8] : {8{fill}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q     <= io.req_we;
        uns_q    <= io.req_unsigned;
        err_q    <= size_bad;
        size_q   <= io.req_size;
        addr_q   <= io.req_addr;
        wdata_q  <= io.req_wdata;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if (state == WAIT0 && io.bus_rvalid) rdata0_q <= io.bus_rdata;
      if (state == WAIT1 && io.bus_rvalid) rdata1_q <= io.bus_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.req_valid) state_nx = size_bad ? RESP : REQ0;
      REQ0:    if (io.bus_ready) state_nx = WAIT0;
      WAIT0:   if (io.bus_rvalid) state_nx = split ? REQ1 : RESP;
      REQ1:    if (io.bus_ready) state_nx = WAIT1;
      WAIT1:   if (io.bus_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign io.req_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  // Bus outputs are functions of state and latched request only, so they
  // cannot move while a beat is stalled on bus_ready.
  assign io.bus_valid = (state == REQ0) || (state == REQ1);
  assign io.bus_we    = io.bus_valid && we_q;
  assign io.bus_addr  = (state == REQ0) ? base_addr :
                        (state == REQ1) ? base_addr + AW'(NB) : '0;
  assign io.bus_wstrb = !io.bus_we      ? '0 :
                        (state == REQ1) ? strb_sh[2*NB-1:NB] : strb_sh[NB-1:0];
  assign io.bus_wdata = !io.bus_we      ? '0 :
                        (state == REQ1) ? wd_sh[2*DW-1:DW] : wd_sh[DW-1:0];

  assign io.resp_valid = (state == RESP);
  assign io.resp_err   = (state == RESP) && err_q;
  assign io.resp_rdata = (state == RESP && !we_q && !err_q) ? load_data : '0;
endmodule
